// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader and its accumulator.
package instruction_loader_pkg;

  localparam int INSTR_W       = 8;
  localparam int ADDR_W        = 8;
  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  // An 8-bit length field of 0 stands for a full 256-word image.
  function automatic logic [8:0] decode_length(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and RAM write port of the instruction loader.
//
// Handshake: a byte moves from source to loader on every rising edge where
// In_Valid and In_Ready are both 1. The source holds In_Data stable while
// In_Valid is 1 and the byte has not been taken; In_Ready never depends on
// In_Valid. Write_Enable is a one-cycle strobe per word, no back-pressure.
interface instruction_loader_if;
  import instruction_loader_pkg::*;

  logic [INSTR_W-1:0] In_Data;
  logic               In_Valid;
  logic               In_Ready;
  logic               Write_Enable;
  logic [ADDR_W-1:0]  Write_Address;
  logic [INSTR_W-1:0] Write_Data;

  // Host / byte source side.
  modport master (
    output In_Data, In_Valid,
    input  In_Ready, Write_Enable, Write_Address, Write_Data
  );

  // Loader side.
  modport slave (
    input  In_Data, In_Valid,
    output In_Ready, Write_Enable, Write_Address, Write_Data
  );
endinterface

// File: rtl/instruction_loader_xor_accum.sv
// Clearable, enable-gated XOR accumulator used for the load checksum.
module xor_accum
  import instruction_loader_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Clear wins over accumulate so a new load always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ d_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/instruction_loader.sv
// Streams instruction bytes into the instruction RAM, verifies a trailing
// XOR checksum and holds the CPU while the image is being rewritten.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [7:0]         Length,
  instruction_loader_if.slave bus,
  output logic               CPU_Hold,
  output logic               Done,
  output logic               Error,
  output loader_state_t      dbg_state_o
);

  localparam logic [8:0] DEPTH_N = 9'(DEPTH);

  loader_state_t      state_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic [ADDR_W-1:0]  cnt_d;
  logic [ADDR_W-1:0]  last_q;
  logic               in_ready_q;
  logic               we_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [INSTR_W-1:0] wdata_q;
  logic               hold_q;
  logic               done_q;
  logic               error_q;

  logic               start_window;
  logic [8:0]         n_len;
  logic               range_err;
  logic               start_load;
  logic               accept;
  logic               acc_en;
  logic [INSTR_W-1:0] acc;

  // Start is only looked at when no load is in flight.
  assign start_window = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                        (state_q == ST_ERROR);
  assign n_len        = decode_length(Length);
  assign range_err    = (n_len > DEPTH_N);
  assign start_load   = start_window && Start && !range_err;
  assign accept       = bus.In_Valid && in_ready_q;
  assign acc_en       = (state_q == ST_LOAD) && accept;
  assign cnt_d        = cnt_q + 8'd1;

  xor_accum #(.W(INSTR_W)) u_xor_accum (
    .clk   (clk),
    .reset (reset),
    .clr_i (start_load),
    .en_i  (acc_en),
    .d_i   (bus.In_Data),
    .acc_o (acc)
  );

  // Load FSM with word counter, write register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (Start) begin
            done_q <= 1'b0;
            hold_q <= 1'b1;
            if (range_err) begin
              state_q    <= ST_ERROR;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= ST_LOAD;
              error_q    <= 1'b0;
              in_ready_q <= 1'b1;
              cnt_q      <= '0;
              // Storing N-1 lets 256 fit in 8 bits (0 - 1 wraps to 255).
              last_q     <= Length - 8'd1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= bus.In_Data;
            cnt_q   <= cnt_d;
            if (cnt_q == last_q) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          // The checksum byte is compared only, never written.
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.In_Data == acc) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          hold_q     <= 1'b0;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.In_Ready      = in_ready_q;
  assign bus.Write_Enable  = we_q;
  assign bus.Write_Address = waddr_q;
  assign bus.Write_Data    = wdata_q;
  assign CPU_Hold          = hold_q;
  assign Done              = done_q;
  assign Error             = error_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table of whole loads plus hand-written
// sequences for gaps, reset mid-load and the length range check.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  instruction_loader_if bus();
  logic          Start = 1'b0;
  logic [7:0]    Length = 8'd0;
  logic          CPU_Hold, Done, Error;
  loader_state_t state;

  instruction_loader #(.DEPTH(256)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Length(Length), .bus(bus),
    .CPU_Hold(CPU_Hold), .Done(Done), .Error(Error), .dbg_state_o(state)
  );

  instruction_loader_if bus16();
  logic          Start16 = 1'b0;
  logic [7:0]    Length16 = 8'd0;
  logic          CPU_Hold16, Done16, Error16;
  loader_state_t state16;

  instruction_loader #(.DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .Start(Start16), .Length(Length16), .bus(bus16),
    .CPU_Hold(CPU_Hold16), .Done(Done16), .Error(Error16), .dbg_state_o(state16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int viol16   = 0;
  logic [47:0] exp_q[$];   // {cycle, address, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every write must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (bus.Write_Enable === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {cyc[31:0], bus.Write_Address, bus.Write_Data}, 48'h0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("write", {cyc[31:0], bus.Write_Address, bus.Write_Data}, e);
      end
    end
    if (bus16.In_Ready !== 1'b0 || bus16.Write_Enable !== 1'b0) viol16++;
  end

  // ---------------- drivers ----------------
  logic [7:0] buf_data[0:255];
  int         buf_gap[0:256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte, waits (bounded) for In_Ready, then lets it be accepted.
  task automatic send_byte(input logic [7:0] b, input logic push, input logic [7:0] addr,
                           output logic ok);
    int t;
    t = 0;
    bus.In_Valid = 1'b1;
    bus.In_Data  = b;
    while (bus.In_Ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("in_ready", bus.In_Ready, 1'b1);
    if (bus.In_Ready !== 1'b1) begin
      bus.In_Valid = 1'b0;
      ok = 1'b0;
      return;
    end
    tick();
    if (push) exp_q.push_back({cyc[31:0], addr, b});
    bus.In_Valid = 1'b0;
    ok = 1'b1;
  endtask

  // Full load: Start, nb data bytes (with buf_gap idle cycles before each), checksum.
  task automatic do_load(input string name, input logic [7:0] len, input int nb,
                         input logic [7:0] cks, input logic exp_done, input logic exp_err);
    logic ok;
    int   wc0;
    Start  = 1'b1;
    Length = len;
    tick();
    Start = 1'b0;
    check({name, "_hold_rise"}, CPU_Hold, 1'b1);
    check({name, "_state_load"}, state, ST_LOAD);
    wc0 = wr_cnt;
    for (int i = 0; i < nb; i++) begin
      repeat (buf_gap[i]) tick();
      send_byte(buf_data[i], 1'b1, 8'(i), ok);
      if (!ok) return;
    end
    repeat (buf_gap[nb]) tick();
    send_byte(cks, 1'b0, 8'h00, ok);
    if (!ok) return;
    check({name, "_done"}, Done, exp_done);
    check({name, "_error"}, Error, exp_err);
    check({name, "_hold"}, CPU_Hold, exp_err);
    check({name, "_in_ready_low"}, bus.In_Ready, 1'b0);
    tick();
    check({name, "_writes_drained"}, exp_q.size(), 0);
    check({name, "_write_count"}, wr_cnt - wc0, nb);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] len;
    int         nb;
    logic [7:0] d[8];
    logic [7:0] cks;
    logic       gen;      // random data, bench-computed checksum
    logic       bad;      // flip checksum LSB on generated data
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       ok;
    logic [7:0] x;

    vecs[0] = '{"nominal",  8'd5, 5, '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 0, 0, 0}, 8'h5F, 0, 0, 1, 0};
    vecs[1] = '{"restart1", 8'd1, 1, '{8'hC3, 0, 0, 0, 0, 0, 0, 0},                 8'hC3, 0, 0, 1, 0};
    vecs[2] = '{"badcks",   8'd5, 5, '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 0, 0, 0}, 8'h5E, 0, 0, 0, 1};
    vecs[3] = '{"from_err", 8'd5, 5, '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 0, 0, 0}, 8'h5F, 0, 0, 1, 0};
    vecs[4] = '{"full256",  8'd0, 256, '{0, 0, 0, 0, 0, 0, 0, 0},                   8'h00, 1, 0, 1, 0};
    vecs[5] = '{"rand_bad", 8'd3, 3, '{0, 0, 0, 0, 0, 0, 0, 0},                     8'h00, 1, 1, 0, 1};

    bus.In_Valid   = 1'b0;
    bus.In_Data    = 8'h00;
    bus16.In_Valid = 1'b0;
    bus16.In_Data  = 8'h00;
    for (int i = 0; i <= 256; i++) buf_gap[i] = 0;

    // Reset values
    repeat (3) tick();
    check("rst_state", state, ST_IDLE);
    check("rst_in_ready", bus.In_Ready, 1'b0);
    check("rst_we", bus.Write_Enable, 1'b0);
    check("rst_waddr", bus.Write_Address, 8'h00);
    check("rst_wdata", bus.Write_Data, 8'h00);
    check("rst_hold", CPU_Hold, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_error", Error, 1'b0);
    reset = 1'b0;
    tick();

    // Table-driven loads, In_Valid held high
    for (int v = 0; v < 6; v++) begin
      x = 8'h00;
      for (int i = 0; i < vecs[v].nb; i++) begin
        buf_data[i] = vecs[v].gen ? 8'($urandom_range(0, 255)) : vecs[v].d[i];
        x ^= buf_data[i];
      end
      if (vecs[v].gen) x = x ^ {7'd0, vecs[v].bad};
      else x = vecs[v].cks;
      do_load(vecs[v].name, vecs[v].len, vecs[v].nb, x, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Gapped valid: pattern 1,0,0,1,0,1,1
    buf_data[0] = 8'h12; buf_data[1] = 8'h34; buf_data[2] = 8'h56;
    buf_gap[1] = 2; buf_gap[2] = 1;
    do_load("gapped", 8'd3, 3, 8'h12 ^ 8'h34 ^ 8'h56, 1'b1, 1'b0);
    buf_gap[1] = 0; buf_gap[2] = 0;

    // Reset after the 2nd accepted byte of a 5-word load; the 3rd byte is
    // offered on the reset edge and must not be written.
    Start = 1'b1; Length = 8'd5;
    tick();
    Start = 1'b0;
    send_byte(8'hA1, 1'b1, 8'h00, ok);
    send_byte(8'hB2, 1'b1, 8'h01, ok);
    reset = 1'b1;
    bus.In_Valid = 1'b1;
    bus.In_Data  = 8'hC4;
    tick();
    bus.In_Valid = 1'b0;
    check("midrst_state", state, ST_IDLE);
    check("midrst_we", bus.Write_Enable, 1'b0);
    check("midrst_waddr", bus.Write_Address, 8'h00);
    check("midrst_wdata", bus.Write_Data, 8'h00);
    check("midrst_in_ready", bus.In_Ready, 1'b0);
    check("midrst_hold", CPU_Hold, 1'b0);
    check("midrst_done", Done, 1'b0);
    check("midrst_error", Error, 1'b0);
    reset = 1'b0;
    tick();
    buf_data[0] = 8'h5A; buf_data[1] = 8'hA5;
    do_load("after_rst", 8'd2, 2, 8'hFF, 1'b1, 1'b0);

    // Range check on the DEPTH=16 instance, with In_Valid tempting it
    viol16 = 0;
    bus16.In_Valid = 1'b1;
    bus16.In_Data  = 8'hAA;
    Start16 = 1'b1; Length16 = 8'd17;
    tick();
    Start16 = 1'b0;
    check("range_state", state16, ST_ERROR);
    check("range_error", Error16, 1'b1);
    check("range_hold", CPU_Hold16, 1'b1);
    check("range_done", Done16, 1'b0);
    repeat (4) tick();
    check("range_error_held", Error16, 1'b1);
    check("range_no_ready_no_write", viol16, 0);
    // Length 0 means 256, also out of range for 16
    Start16 = 1'b1; Length16 = 8'd0;
    tick();
    Start16 = 1'b0;
    check("range256_state", state16, ST_ERROR);
    check("range256_no_ready_no_write", viol16, 0);
    // Length 16 is exactly DEPTH and must be accepted
    bus16.In_Valid = 1'b0;
    Start16 = 1'b1; Length16 = 8'd16;
    tick();
    Start16 = 1'b0;
    check("range16_state", state16, ST_LOAD);
    check("range16_error_clr", Error16, 1'b0);
    check("range16_ready", bus16.In_Ready, 1'b1);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
